bru_pred: RTL and testbench

BRU_PRED -- requirements
Module: bru_pred

---
 rtl/bru_pred_pkg.sv | 42 ++++
 rtl/bru_pred_if.sv | 59 +++++
 rtl/bru_pred_wb_fifo.sv | 67 ++++++
 rtl/bru_pred.sv | 176 +++++++++++++++++
 tb/tb_bru_pred.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bru_pred_pkg.sv
// Shared types for the branch resolve unit. The structs are sized by the default
// configuration (BR_* localparams), which the bru_pred parameters default to.
package branch_types;

    localparam int BR_XLEN     = 32;
    localparam int BR_ROB_BITS = 5;
    localparam int BR_NUM_BR   = 4;
    localparam int BR_TAG_W    = (BR_NUM_BR > 1) ? $clog2(BR_NUM_BR) : 1;
    localparam int BR_PD_W     = 7;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'd0,
        KIND_JAL    = 2'd1,
        KIND_JALR   = 2'd2
    } bru_kind_t;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'd0,
        F3_BNE  = 3'd1,
        F3_BLT  = 3'd4,
        F3_BGE  = 3'd5,
        F3_BLTU = 3'd6,
        F3_BGEU = 3'd7
    } branch_f3_t;

    typedef struct packed {
        logic                   mispred;
        logic [BR_XLEN-1:0]     tgt;
        logic [BR_TAG_W-1:0]    tag;
        logic [BR_ROB_BITS-1:0] rob;
        logic [BR_NUM_BR-1:0]   mask;
    } bru_res_t;

    typedef struct packed {
        logic [BR_XLEN-1:0]     data;
        logic [BR_PD_W-1:0]     pd;
        logic [BR_ROB_BITS-1:0] rob;
        logic                   exc;
        logic [BR_NUM_BR-1:0]   mask;
    } bru_wb_t;

endpackage

// File: rtl/bru_pred_if.sv
// Issue, kill/clear, resolve and writeback signals of the branch resolve unit.
interface bru_pred_if #(
    parameter int XLEN     = 32,
    parameter int ROB_BITS = 5,
    parameter int NUM_BR   = 4
);
    localparam int TAG_W = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;

    logic                iss_valid;
    logic                iss_ready;
    logic [1:0]          iss_kind;
    logic [2:0]          iss_f3;
    logic [XLEN-1:0]     iss_a;
    logic [XLEN-1:0]     iss_b;
    logic [XLEN-1:0]     iss_imm;
    logic [XLEN-1:0]     iss_pc;
    logic                iss_pred_taken;
    logic [XLEN-1:0]     iss_pred_tgt;
    logic [ROB_BITS-1:0] iss_rob;
    logic [6:0]          iss_pd;
    logic [TAG_W-1:0]    iss_tag;
    logic [NUM_BR-1:0]   iss_mask;

    logic                kill_valid;
    logic [TAG_W-1:0]    kill_tag;
    logic                clr_valid;
    logic [TAG_W-1:0]    clr_tag;

    logic                res_valid;
    logic                res_mispred;
    logic [XLEN-1:0]     res_tgt;
    logic [TAG_W-1:0]    res_tag;
    logic [ROB_BITS-1:0] res_rob;
    logic [NUM_BR-1:0]   res_mask;

    logic                wb_valid;
    logic                wb_ready;
    logic [XLEN-1:0]     wb_data;
    logic [6:0]          wb_pd;
    logic [ROB_BITS-1:0] wb_rob;
    logic                wb_exc;

    modport master (
        output iss_valid, iss_kind, iss_f3, iss_a, iss_b, iss_imm, iss_pc,
               iss_pred_taken, iss_pred_tgt, iss_rob, iss_pd, iss_tag, iss_mask,
               kill_valid, kill_tag, clr_valid, clr_tag, wb_ready,
        input  iss_ready, res_valid, res_mispred, res_tgt, res_tag, res_rob, res_mask,
               wb_valid, wb_data, wb_pd, wb_rob, wb_exc
    );

    modport slave (
        input  iss_valid, iss_kind, iss_f3, iss_a, iss_b, iss_imm, iss_pc,
               iss_pred_taken, iss_pred_tgt, iss_rob, iss_pd, iss_tag, iss_mask,
               kill_valid, kill_tag, clr_valid, clr_tag, wb_ready,
        output iss_ready, res_valid, res_mispred, res_tgt, res_tag, res_rob, res_mask,
               wb_valid, wb_data, wb_pd, wb_rob, wb_exc
    );

endinterface

// File: rtl/bru_pred_wb_fifo.sv
// Writeback FIFO for resolved branches; entries are dropped by branch kill and
// compacted toward the head so the remaining order is preserved.
module bru_wb_fifo
    import branch_types::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = BR_TAG_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  bru_wb_t    push_ent,
    output logic       can_push,
    input  logic       pop,
    input  logic       kill_valid,
    input  logic [TAG_W-1:0] kill_tag,
    input  logic       clr_valid,
    input  logic [TAG_W-1:0] clr_tag,
    output logic       head_valid,
    output bru_wb_t    head
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = IDX_W + 1;

    bru_wb_t          ent_q [DEPTH];
    bru_wb_t          ent_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [BR_NUM_BR-1:0] clr_bits;

    assign clr_bits   = clr_valid ? (BR_NUM_BR'(1) << clr_tag) : '0;
    assign head_valid = (cnt_q != '0);
    assign head       = ent_q[0];
    assign can_push   = (cnt_q != CNT_W'(DEPTH)) || pop;

    // Survivors are repacked from slot 0 upward; the push lands behind them.
    always_comb begin
        ent_d = ent_q;
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < cnt_q) && !(pop && (i == 0)) &&
                !(kill_valid && ent_q[i].mask[kill_tag])) begin
                ent_d[cnt_d[IDX_W-1:0]]      = ent_q[i];
                ent_d[cnt_d[IDX_W-1:0]].mask = ent_q[i].mask & ~clr_bits;
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
        if (push) begin
            ent_d[cnt_d[IDX_W-1:0]]      = push_ent;
            ent_d[cnt_d[IDX_W-1:0]].mask = push_ent.mask & ~clr_bits;
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

endmodule

// File: rtl/bru_pred.sv
// Branch resolve unit: one execute register feeding a maskable writeback FIFO.
// Optional macro BRU_MISALIGN_EN flags taken targets with bit 1 set as exceptions.
module bru_pred
    import branch_types::*;
#(
    parameter int XLEN     = BR_XLEN,
    parameter int ROB_BITS = BR_ROB_BITS,
    parameter int NUM_BR   = BR_NUM_BR,
    parameter int WB_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    bru_pred_if.slave bus
);
    localparam int TAG_W = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;

    logic                e_valid_q, e_valid_d;
    logic [1:0]          e_kind_q, e_kind_d;
    logic [2:0]          e_f3_q, e_f3_d;
    logic [XLEN-1:0]     e_a_q, e_a_d;
    logic [XLEN-1:0]     e_b_q, e_b_d;
    logic [XLEN-1:0]     e_imm_q, e_imm_d;
    logic [XLEN-1:0]     e_pc_q, e_pc_d;
    logic                e_pt_q, e_pt_d;
    logic [XLEN-1:0]     e_ptgt_q, e_ptgt_d;
    logic [ROB_BITS-1:0] e_rob_q, e_rob_d;
    logic [6:0]          e_pd_q, e_pd_d;
    logic [TAG_W-1:0]    e_tag_q, e_tag_d;
    logic [NUM_BR-1:0]   e_mask_q, e_mask_d;

    logic              accept, iss_drop, e_kill, e_move;
    logic              fifo_can_push, fifo_pop, fifo_head_valid;
    logic [NUM_BR-1:0] clr_bits;
    logic              taken, mis_raw, misalign;
    logic [XLEN-1:0]   tgt_jump, seq_pc, act_tgt;
    logic signed [XLEN-1:0] a_s, b_s;
    bru_res_t          res;
    bru_wb_t           wb_push, wb_head;

    assign clr_bits = bus.clr_valid ? (NUM_BR'(1) << bus.clr_tag) : '0;
    assign e_kill   = bus.kill_valid && e_mask_q[bus.kill_tag];
    assign e_move   = e_valid_q && !e_kill && fifo_can_push;
    assign accept   = bus.iss_valid && bus.iss_ready;
    assign iss_drop = bus.kill_valid && bus.iss_mask[bus.kill_tag];
    assign fifo_pop = fifo_head_valid && bus.wb_ready;

    assign bus.iss_ready = !e_valid_q || e_move;

    always_comb begin
        e_valid_d = e_valid_q;
        if (accept) begin
            e_valid_d = !iss_drop;
        end else if (e_move || e_kill) begin
            e_valid_d = 1'b0;
        end
        e_kind_d = accept ? bus.iss_kind       : e_kind_q;
        e_f3_d   = accept ? bus.iss_f3         : e_f3_q;
        e_a_d    = accept ? bus.iss_a          : e_a_q;
        e_b_d    = accept ? bus.iss_b          : e_b_q;
        e_imm_d  = accept ? bus.iss_imm        : e_imm_q;
        e_pc_d   = accept ? bus.iss_pc         : e_pc_q;
        e_pt_d   = accept ? bus.iss_pred_taken : e_pt_q;
        e_ptgt_d = accept ? bus.iss_pred_tgt   : e_ptgt_q;
        e_rob_d  = accept ? bus.iss_rob        : e_rob_q;
        e_pd_d   = accept ? bus.iss_pd         : e_pd_q;
        e_tag_d  = accept ? bus.iss_tag        : e_tag_q;
        e_mask_d = (accept ? bus.iss_mask : e_mask_q) & ~clr_bits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q <= 1'b0;
        end else begin
            e_valid_q <= e_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        e_kind_q <= e_kind_d;
        e_f3_q   <= e_f3_d;
        e_a_q    <= e_a_d;
        e_b_q    <= e_b_d;
        e_imm_q  <= e_imm_d;
        e_pc_q   <= e_pc_d;
        e_pt_q   <= e_pt_d;
        e_ptgt_q <= e_ptgt_d;
        e_rob_q  <= e_rob_d;
        e_pd_q   <= e_pd_d;
        e_tag_q  <= e_tag_d;
        e_mask_q <= e_mask_d;
    end

    // Execute stage: condition, target and prediction check on the E register.
    assign a_s = e_a_q;
    assign b_s = e_b_q;

    always_comb begin
        taken = 1'b0;
        case (branch_f3_t'(e_f3_q))
            F3_BEQ:  taken = (e_a_q == e_b_q);
            F3_BNE:  taken = (e_a_q != e_b_q);
            F3_BLT:  taken = (a_s < b_s);
            F3_BGE:  taken = (a_s >= b_s);
            F3_BLTU: taken = (e_a_q < e_b_q);
            F3_BGEU: taken = (e_a_q >= e_b_q);
            default: taken = 1'b0;
        endcase
        if (bru_kind_t'(e_kind_q) != KIND_BRANCH) begin
            taken = 1'b1;
        end
    end

    assign tgt_jump = (bru_kind_t'(e_kind_q) == KIND_JALR) ?
                      ((e_a_q + e_imm_q) & ~XLEN'(1)) : (e_pc_q + e_imm_q);
    assign seq_pc   = e_pc_q + XLEN'(4);
    assign act_tgt  = taken ? tgt_jump : seq_pc;
    assign mis_raw  = (taken != e_pt_q) || (taken && (tgt_jump != e_ptgt_q));

    always_comb begin
        res      = '0;
        res.tag  = e_tag_q;
        res.rob  = e_rob_q;
        res.mask = e_mask_q;
`ifdef BRU_MISALIGN_EN
        // A misaligned taken target raises an exception at commit instead of redirecting.
        misalign    = taken && tgt_jump[1];
        res.mispred = misalign ? 1'b0 : mis_raw;
        res.tgt     = misalign ? (e_pt_q ? e_ptgt_q : seq_pc) : act_tgt;
`else
        misalign    = 1'b0;
        res.mispred = mis_raw;
        res.tgt     = act_tgt;
`endif
    end

    always_comb begin
        wb_push      = '0;
        wb_push.data = (bru_kind_t'(e_kind_q) == KIND_BRANCH) ? '0 : seq_pc;
        wb_push.pd   = e_pd_q;
        wb_push.rob  = e_rob_q;
        wb_push.exc  = misalign;
        wb_push.mask = e_mask_q;
    end

    assign bus.res_valid   = e_move;
    assign bus.res_mispred = res.mispred;
    assign bus.res_tgt     = res.tgt;
    assign bus.res_tag     = res.tag;
    assign bus.res_rob     = res.rob;
    assign bus.res_mask    = res.mask;

    bru_wb_fifo #(
        .DEPTH (WB_DEPTH),
        .TAG_W (TAG_W)
    ) u_wb_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (e_move),
        .push_ent   (wb_push),
        .can_push   (fifo_can_push),
        .pop        (fifo_pop),
        .kill_valid (bus.kill_valid),
        .kill_tag   (bus.kill_tag),
        .clr_valid  (bus.clr_valid),
        .clr_tag    (bus.clr_tag),
        .head_valid (fifo_head_valid),
        .head       (wb_head)
    );

    assign bus.wb_valid = fifo_head_valid;
    assign bus.wb_data  = wb_head.data;
    assign bus.wb_pd    = wb_head.pd;
    assign bus.wb_rob   = wb_head.rob;
    assign bus.wb_exc   = wb_head.exc;

endmodule

// File: tb/tb_bru_pred.sv
// Scoreboard bench for bru_pred: directed issues push expected resolve and
// writeback records; a negedge monitor pops and compares them.
module tb_bru_pred;

    localparam logic EXC_EN =
`ifdef BRU_MISALIGN_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bru_pred_if #(.XLEN(32), .ROB_BITS(5), .NUM_BR(4)) bus();

    bru_pred #(.XLEN(32), .ROB_BITS(5), .NUM_BR(4), .WB_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        mis;
        logic [31:0] tgt;
        logic [4:0]  rob;
    } res_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rob;
        logic [6:0]  pd;
        logic        exc;
    } wb_exp_t;

    res_exp_t res_q[$];
    wb_exp_t  wb_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_res(input logic m, input logic [31:0] t, input logic [4:0] r);
        res_exp_t e;
        e.mis = m; e.tgt = t; e.rob = r;
        res_q.push_back(e);
    endtask

    task automatic exp_wb(input logic [31:0] d, input logic [4:0] r, input logic [6:0] p, input logic x);
        wb_exp_t e;
        e.data = d; e.rob = r; e.pd = p; e.exc = x;
        wb_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] kind, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic pt, input logic [31:0] ptgt,
                         input logic [4:0] rob, input logic [6:0] pd,
                         input logic [1:0] tag, input logic [3:0] mask);
        int n = 0;
        bus.iss_valid = 1'b1; bus.iss_kind = kind; bus.iss_f3 = f3;
        bus.iss_a = a; bus.iss_b = b; bus.iss_imm = imm; bus.iss_pc = pc;
        bus.iss_pred_taken = pt; bus.iss_pred_tgt = ptgt;
        bus.iss_rob = rob; bus.iss_pd = pd; bus.iss_tag = tag; bus.iss_mask = mask;
        while (!bus.iss_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.iss_ready) begin
            checks++; failures++;
            $display("FAIL issue_timeout rob=%0d actual=not_ready required=ready", rob);
        end
        @(posedge clk); #1;
        bus.iss_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every resolve and every accepted writeback in order.
    always @(negedge clk) begin
        res_exp_t r;
        wb_exp_t  w;
        if (!rst) begin
            if (bus.res_valid) begin
                if (res_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL res_unexpected actual_rob=%0d required=none", bus.res_rob);
                end else begin
                    r = res_q.pop_front();
                    chk("res_rob", 32'(bus.res_rob), 32'(r.rob));
                    chk("res_mispred", 32'(bus.res_mispred), 32'(r.mis));
                    chk("res_tgt", bus.res_tgt, r.tgt);
                end
            end
            if (bus.wb_valid && bus.wb_ready) begin
                if (wb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wb_unexpected actual_rob=%0d required=none", bus.wb_rob);
                end else begin
                    w = wb_q.pop_front();
                    chk("wb_rob", 32'(bus.wb_rob), 32'(w.rob));
                    chk("wb_data", bus.wb_data, w.data);
                    chk("wb_pd", 32'(bus.wb_pd), 32'(w.pd));
                    chk("wb_exc", 32'(bus.wb_exc), 32'(w.exc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.iss_valid = 0; bus.iss_kind = 0; bus.iss_f3 = 0; bus.iss_a = 0; bus.iss_b = 0;
        bus.iss_imm = 0; bus.iss_pc = 0; bus.iss_pred_taken = 0; bus.iss_pred_tgt = 0;
        bus.iss_rob = 0; bus.iss_pd = 0; bus.iss_tag = 0; bus.iss_mask = 0;
        bus.kill_valid = 0; bus.kill_tag = 0; bus.clr_valid = 0; bus.clr_tag = 0;
        bus.wb_ready = 1;

        cycles(2);
        @(negedge clk);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_iss_ready", 32'(bus.iss_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // BEQ taken but predicted not-taken; checks one-cycle resolve latency.
        exp_res(1'b1, 32'h120, 5'd1); exp_wb(32'h0, 5'd1, 7'd3, 1'b0);
        issue(2'd0, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 32'h0, 5'd1, 7'd3, 2'd0, 4'b0000);
        @(negedge clk);
        chk("lat_res_valid_n1", 32'(bus.res_valid), 32'd1);
        chk("lat_wb_valid_n1", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        chk("lat_wb_valid_n2", 32'(bus.wb_valid), 32'd1);
        cycles(1);

        exp_res(1'b0, 32'h1006, 5'd2); exp_wb(32'h204, 5'd2, 7'd5, EXC_EN);
        issue(2'd2, 3'd0, 32'h1003, 32'h0, 32'h4, 32'h200, 1'b1, 32'h1006, 5'd2, 7'd5, 2'd0, 4'b0000);
        exp_res(1'b0, 32'h340, 5'd3); exp_wb(32'h0, 5'd3, 7'd6, 1'b0);
        issue(2'd0, 3'd1, 32'd1, 32'd2, 32'h40, 32'h300, 1'b1, 32'h340, 5'd3, 7'd6, 2'd0, 4'b0000);
        exp_res(1'b0, 32'h3F8, 5'd4); exp_wb(32'h0, 5'd4, 7'd7, 1'b0);
        issue(2'd0, 3'd4, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF8, 32'h400, 1'b1, 32'h3F8, 5'd4, 7'd7, 2'd0, 4'b0000);
        exp_res(1'b1, 32'h504, 5'd5); exp_wb(32'h0, 5'd5, 7'd8, 1'b0);
        issue(2'd0, 3'd6, 32'hFFFFFFFF, 32'd1, 32'h10, 32'h500, 1'b1, 32'h510, 5'd5, 7'd8, 2'd0, 4'b0000);
        exp_res(1'b0, 32'h554, 5'd6); exp_wb(32'h0, 5'd6, 7'd9, 1'b0);
        issue(2'd0, 3'd5, 32'hFFFFFFFB, 32'd3, 32'h10, 32'h550, 1'b0, 32'h0, 5'd6, 7'd9, 2'd0, 4'b0000);
        exp_res(1'b1, 32'h700, 5'd7); exp_wb(32'h0, 5'd7, 7'd10, 1'b0);
        issue(2'd0, 3'd7, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h600, 1'b0, 32'h0, 5'd7, 7'd10, 2'd0, 4'b0000);
        exp_res(1'b1, 32'h880, 5'd8); exp_wb(32'h804, 5'd8, 7'd11, 1'b0);
        issue(2'd1, 3'd0, 32'h0, 32'h0, 32'h80, 32'h800, 1'b1, 32'h900, 5'd8, 7'd11, 2'd0, 4'b0000);
        exp_res(1'b0, 32'h6, 5'd9); exp_wb(32'h4, 5'd9, 7'd12, EXC_EN);
        issue(2'd1, 3'd0, 32'h0, 32'h0, 32'h6, 32'h0, 1'b1, 32'h6, 5'd9, 7'd12, 2'd0, 4'b0000);
        cycles(4);

        // Back-pressure: third branch stalls in E until writeback drains.
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_res(1'b0, 32'h1004 + 32'(4 * i), 5'(10 + i));
            exp_wb(32'h0, 5'(10 + i), 7'(20 + i), 1'b0);
            issue(2'd0, 3'd0, 32'd1, 32'd2, 32'h10, 32'h1000 + 32'(4 * i), 1'b0, 32'h0,
                  5'(10 + i), 7'(20 + i), 2'd0, 4'b0000);
        end
        @(negedge clk);
        chk("bp_iss_ready", 32'(bus.iss_ready), 32'd0);
        chk("bp_head_rob", 32'(bus.wb_rob), 32'd10);
        cycles(3);
        @(negedge clk);
        chk("bp_head_stable", 32'(bus.wb_rob), 32'd10);
        chk("bp_res_held", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;
        bus.wb_ready = 1'b1;
        cycles(6);

        // Kill tag1 removes the head entry; the unmasked entry moves to the head.
        bus.wb_ready = 1'b0;
        exp_res(1'b0, 32'h2004, 5'd20);
        issue(2'd0, 3'd0, 32'd1, 32'd2, 32'h10, 32'h2000, 1'b0, 32'h0, 5'd20, 7'd30, 2'd1, 4'b0010);
        exp_res(1'b0, 32'h2008, 5'd21); exp_wb(32'h0, 5'd21, 7'd31, 1'b0);
        issue(2'd0, 3'd0, 32'd1, 32'd2, 32'h10, 32'h2004, 1'b0, 32'h0, 5'd21, 7'd31, 2'd0, 4'b0000);
        cycles(1);
        bus.kill_valid = 1'b1; bus.kill_tag = 2'd1;
        cycles(1);
        bus.kill_valid = 1'b0;
        @(negedge clk);
        chk("kill_head_valid", 32'(bus.wb_valid), 32'd1);
        chk("kill_head_rob", 32'(bus.wb_rob), 32'd21);
        @(posedge clk); #1;
        bus.wb_ready = 1'b1;
        cycles(4);

        // Same-cycle clear strips tag2 from the issuing mask; a later kill tag2 is harmless.
        bus.wb_ready = 1'b0;
        bus.clr_valid = 1'b1; bus.clr_tag = 2'd2;
        exp_res(1'b0, 32'h3004, 5'd22); exp_wb(32'h0, 5'd22, 7'd32, 1'b0);
        issue(2'd0, 3'd0, 32'd1, 32'd2, 32'h10, 32'h3000, 1'b0, 32'h0, 5'd22, 7'd32, 2'd0, 4'b0100);
        bus.clr_valid = 1'b0;
        @(negedge clk);
        chk("clr_res_mask", 32'(bus.res_mask), 32'h0);
        @(posedge clk); #1;
        bus.kill_valid = 1'b1; bus.kill_tag = 2'd2;
        cycles(1);
        bus.kill_valid = 1'b0;
        @(negedge clk);
        chk("clr_survives_kill", 32'(bus.wb_rob), 32'd22);
        @(posedge clk); #1;
        bus.wb_ready = 1'b1;
        cycles(3);

        // Issue concurrent with a kill on its own mask: accepted then dropped.
        bus.kill_valid = 1'b1; bus.kill_tag = 2'd3;
        issue(2'd1, 3'd0, 32'h0, 32'h0, 32'h40, 32'h3100, 1'b1, 32'h3140, 5'd23, 7'd33, 2'd0, 4'b1000);
        bus.kill_valid = 1'b0;
        @(negedge clk);
        chk("drop_res_valid", 32'(bus.res_valid), 32'd0);
        chk("drop_iss_ready", 32'(bus.iss_ready), 32'd1);
        cycles(3);

        // Blocked E killed: no resolve for it, issue reopens.
        bus.wb_ready = 1'b0;
        exp_res(1'b0, 32'h4004, 5'd24); exp_wb(32'h0, 5'd24, 7'd34, 1'b0);
        issue(2'd0, 3'd0, 32'd1, 32'd2, 32'h10, 32'h4000, 1'b0, 32'h0, 5'd24, 7'd34, 2'd0, 4'b0000);
        exp_res(1'b0, 32'h4008, 5'd25); exp_wb(32'h0, 5'd25, 7'd35, 1'b0);
        issue(2'd0, 3'd0, 32'd1, 32'd2, 32'h10, 32'h4004, 1'b0, 32'h0, 5'd25, 7'd35, 2'd0, 4'b0000);
        issue(2'd0, 3'd0, 32'd1, 32'd2, 32'h10, 32'h4008, 1'b0, 32'h0, 5'd26, 7'd36, 2'd0, 4'b0001);
        bus.kill_valid = 1'b1; bus.kill_tag = 2'd0;
        cycles(1);
        bus.kill_valid = 1'b0;
        @(negedge clk);
        chk("ekill_iss_ready", 32'(bus.iss_ready), 32'd1);
        @(posedge clk); #1;
        bus.wb_ready = 1'b1;
        cycles(5);

        // Reset with branches in flight discards them all.
        bus.wb_ready = 1'b0;
        exp_res(1'b0, 32'h5004, 5'd27);
        issue(2'd0, 3'd0, 32'd1, 32'd2, 32'h10, 32'h5000, 1'b0, 32'h0, 5'd27, 7'd37, 2'd0, 4'b0000);
        exp_res(1'b0, 32'h5008, 5'd28);
        issue(2'd0, 3'd0, 32'd1, 32'd2, 32'h10, 32'h5004, 1'b0, 32'h0, 5'd28, 7'd38, 2'd0, 4'b0000);
        issue(2'd0, 3'd0, 32'd1, 32'd2, 32'h10, 32'h5008, 1'b0, 32'h0, 5'd29, 7'd39, 2'd0, 4'b0000);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        bus.wb_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_iss_ready", 32'(bus.iss_ready), 32'd1);
        cycles(4);

        // JAL wrapping past 2^32.
        exp_res(1'b0, 32'h4, 5'd30); exp_wb(32'h0, 5'd30, 7'd40, 1'b0);
        issue(2'd1, 3'd0, 32'h0, 32'h0, 32'h8, 32'hFFFFFFFC, 1'b1, 32'h4, 5'd30, 7'd40, 2'd0, 4'b0000);
        cycles(6);

        chk("res_queue_empty", 32'(res_q.size()), 32'd0);
        chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
